// File: rtl/alu_exec_stage_pkg.sv
// Shared opcode encoding and datapath widths for the ALU execute stage.
package alu_exec_stage_pkg;

  localparam int ALU_W   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: eight operations plus zero/carry/overflow flags.
module alu_core
  import alu_exec_stage_pkg::*;
(
  input  logic [2:0]       i_op,
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  output logic [ALU_W-1:0] o_result,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero
);

  logic [ALU_W-1:0]   w_xor;
  logic [ALU_W-1:0]   w_b_eff;
  logic [ALU_W:0]     w_sum;
  logic               w_sub;
  logic               w_ovf;
  logic [SHAMT_W-1:0] w_shamt;

  alu_xor32 u_xor (
    .i_a (i_a),
    .i_b (i_b),
    .o_y (w_xor)
  );

  // SUB shares the adder as a + ~b + 1, so the top bit is the no-borrow flag.
  assign w_sub   = (alu_op_e'(i_op) == ALU_SUB);
  assign w_b_eff = w_sub ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{ALU_W{1'b0}}, w_sub};
  assign w_ovf   = (i_a[ALU_W-1] == w_b_eff[ALU_W-1]) && (w_sum[ALU_W-1] != i_a[ALU_W-1]);
  assign w_shamt = i_b[SHAMT_W-1:0];

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    o_ovf    = 1'b0;
    case (alu_op_e'(i_op))
      ALU_ADD, ALU_SUB: begin
        o_result = w_sum[ALU_W-1:0];
        o_carry  = w_sum[ALU_W];
        o_ovf    = w_ovf;
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = w_xor;
      ALU_SLL: o_result = i_a << w_shamt;
      ALU_SRL: o_result = i_a >> w_shamt;
      ALU_SRA: o_result = ALU_W'($signed(i_a) >>> w_shamt);
      default: o_result = '0;
    endcase
    o_zero = ~|o_result;
  end

endmodule

// File: rtl/alu_xor32.sv
// 32-bit gate-level XOR block, one primitive gate per bit.
module alu_xor32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  for (genvar i = 0; i < 32; i++) begin : g_bit
    xor u_xor (o_y[i], i_a[i], i_b[i]);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage ALU execute stage: S1 holds operands, S2 holds result and flags,
// with valid/ready handshakes on both sides and a flush that drops in-flight work.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [ALU_W-1:0] in_a,
  input  logic [ALU_W-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [ALU_W-1:0] r_s1_a;
  logic [ALU_W-1:0] r_s1_b;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [ALU_W-1:0] r_s2_result;
  logic             r_s2_zero;
  logic             r_s2_carry;
  logic             r_s2_ovf;
  logic [TAG_W-1:0] r_s2_tag;

  logic             w_s2_adv;
  logic             w_accept;
  logic [ALU_W-1:0] w_result;
  logic             w_zero;
  logic             w_carry;
  logic             w_ovf;

  alu_core u_core (
    .i_op     (r_s1_op),
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .o_result (w_result),
    .o_carry  (w_carry),
    .o_ovf    (w_ovf),
    .o_zero   (w_zero)
  );

  assign w_s2_adv = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready = ~flush & (~r_s1_valid | w_s2_adv);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_tag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_zero   <= 1'b0;
      r_s2_carry  <= 1'b0;
      r_s2_ovf    <= 1'b0;
      r_s2_tag    <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid  <= 1'b1;
        r_s2_result <= w_result;
        r_s2_zero   <= w_zero;
        r_s2_carry  <= w_carry;
        r_s2_ovf    <= w_ovf;
        r_s2_tag    <= r_s1_tag;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= in_op;
        r_s1_a     <= in_a;
        r_s1_b     <= in_b;
        r_s1_tag   <= in_tag;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_zero   = r_s2_zero;
  assign out_carry  = r_s2_carry;
  assign out_ovf    = r_s2_ovf;
  assign out_tag    = r_s2_tag;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed scenarios then random traffic against an
// arithmetic reference model and a FIFO occupancy model of the two-slot pipe.
module tb_alu_exec_stage;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]       in_op;
  logic [31:0]      in_a, in_b, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             out_zero, out_carry, out_ovf;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [31:0]      res;
    logic             z, c, v;
    logic [TAG_W-1:0] tag;
    int               edge_n;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu_exec_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_carry(out_carry), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                 logic [TAG_W-1:0] tag);
    exp_t e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    longint full;
    int sh = int'(b[4:0]);
    e.c = 1'b0; e.v = 1'b0; e.tag = tag; e.edge_n = 0; e.res = '0;
    case (op)
      3'd0: begin
        e.res = 32'(ua + ub);
        e.c   = (ua + ub) > 64'hFFFF_FFFF;
        full  = sa + sb;
        e.v   = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      3'd1: begin
        e.res = 32'(ua - ub);
        e.c   = (ua >= ub);
        full  = sa - sb;
        e.v   = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = 32'(ua << sh);
      3'd6: e.res = 32'(ua >> sh);
      default: e.res = 32'(sa >>> sh);
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(string tag, logic [31:0] res, logic z, logic c, logic v,
                            logic [TAG_W-1:0] t);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".result"}, out_result, res);
    check({tag, ".zero"}, {31'b0, out_zero}, {31'b0, z});
    check({tag, ".carry"}, {31'b0, out_carry}, {31'b0, c});
    check({tag, ".ovf"}, {31'b0, out_ovf}, {31'b0, v});
    check({tag, ".tag"}, {28'b0, out_tag}, {28'b0, t});
  endtask

  task automatic drive(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] t);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = t;
  endtask

  // One clock: check handshake and head-of-queue result, then advance the model.
  task automatic tick();
    logic exp_rdy, exp_vld, acc, cons;
    exp_t e;
    #1;
    exp_rdy = !flush && (q.size() < 2 || out_ready);
    exp_vld = (q.size() > 0) && (q[0].edge_n < edge_cnt);
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_vld});
    if (exp_vld) begin
      check("result", out_result, q[0].res);
      check("flags", {29'b0, out_zero, out_carry, out_ovf}, {29'b0, q[0].z, q[0].c, q[0].v});
      check("tag", {28'b0, out_tag}, {28'b0, q[0].tag});
    end
    acc  = in_valid && exp_rdy;
    cons = exp_vld && out_ready && !flush;
    if (acc) begin
      e = model(in_op, in_a, in_b, in_tag);
    end
    @(posedge clk);
    edge_cnt++;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (cons) void'(q.pop_front());
      if (acc) begin
        e.edge_n = edge_cnt;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  logic [31:0] held;
  logic [31:0] specials [8];

  initial begin
    specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h8000_0000; specials[3] = 32'h7FFF_FFFF;
    specials[4] = 32'h0000_0001; specials[5] = 32'h0000_001F;
    specials[6] = 32'h0000_0020; specials[7] = 32'hF0F0_F0F0;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst.valid", {31'b0, out_valid}, 32'd0);
    check("rst.result", out_result, 32'd0);
    check("rst.flags", {29'b0, out_zero, out_carry, out_ovf}, 32'd0);
    check("rst.tag", {28'b0, out_tag}, 32'd0);
    tick();
    rst = 1'b0;

    // Single ADD with wraparound
    out_ready = 1'b1;
    drive(3'd0, 32'hFFFF_FFFF, 32'h1, 4'd3);
    tick();
    in_valid = 1'b0;
    tick();
    expect_out("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0, 4'd3);
    tick();

    drive(3'd1, 32'h8000_0000, 32'h1, 4'd5);
    tick(); in_valid = 1'b0; tick();
    expect_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 4'd5);
    tick();
    drive(3'd1, 32'h5, 32'h7, 4'd6);
    tick(); in_valid = 1'b0; tick();
    expect_out("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 4'd6);
    tick();

    // Back-to-back XOR, SRA, SLL
    drive(3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 4'd1); tick();
    drive(3'd7, 32'h8000_0000, 32'd4, 4'd2); tick();
    expect_out("b2b_xor", 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0, 4'd1);
    drive(3'd5, 32'h1, 32'd31, 4'd7); tick();
    expect_out("b2b_sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0, 4'd2);
    in_valid = 1'b0; tick();
    expect_out("b2b_sll", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 4'd7);
    tick();

    // Backpressure: two fit, third waits until out_ready returns
    out_ready = 1'b0;
    drive(3'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd8); tick();
    drive(3'd3, 32'h1200_0000, 32'h0000_0034, 4'd9); tick();
    drive(3'd6, 32'h8000_0000, 32'd31, 4'd10); #1;
    check("bp.in_ready_low", {31'b0, in_ready}, 32'd0);
    held = out_result;
    tick(); tick();
    check("bp.hold", out_result, held);
    out_ready = 1'b1; #1;
    check("bp.in_ready_release", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Flush with both stages full
    out_ready = 1'b0;
    drive(3'd0, 32'd10, 32'd20, 4'd11); tick();
    drive(3'd0, 32'd30, 32'd40, 4'd12); tick();
    flush = 1'b1; drive(3'd0, 32'd50, 32'd60, 4'd13); #1;
    check("flush.in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush.out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    drive(3'd0, 32'd2, 32'd3, 4'd14); tick();
    in_valid = 1'b0; tick();
    expect_out("post_flush", 32'd5, 1'b0, 1'b0, 1'b0, 4'd14);
    tick();

    // Reset mid-stream
    out_ready = 1'b0;
    drive(3'd3, 32'hA5A5_0000, 32'h0000_5A5A, 4'd15); tick(); tick();
    in_valid = 1'b0;
    check("midrst.pre_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1; tick();
    check("midrst.valid", {31'b0, out_valid}, 32'd0);
    check("midrst.result", out_result, 32'd0);
    rst = 1'b0; #1;
    check("midrst.in_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      in_b      = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      in_tag    = TAG_W'($urandom);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    check("drain.pending", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
